align_prep: RTL and testbench

ALIGN_PREP -- requirements
Module: align_prep

---
 rtl/align_prep.sv | 150 +++++++++++++++
 tb/tb_align_prep.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/align_prep.sv
// Operand alignment front end for a HUB floating-point adder: orders the two
// operands by magnitude and prepares mantissas and shift distance for the shifter.
module align_prep #(
  parameter int M = 24,
  parameter int E = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [E+M-1:0]   x_in,
  input  logic [E+M-1:0]   y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M+1:0]     mant_large,
  output logic [M+1:0]     mant_small,
  output logic [E:0]       shift_amount,
  output logic [E-1:0]     exp_large,
  output logic             sign_large,
  output logic             sign_small,
  output logic             eff_sub,
  output logic             swapped
);

  localparam int W = E + M;
  localparam int F = M - 1;
  localparam logic [E:0] SHIFT_MAX = (E+1)'(M + 2);

  // Zero exponent encodes zero, so the whole mantissa including the ILSB vanishes.
  function automatic logic [M+1:0] hub_mant(input logic [E-1:0] ex, input logic [F-1:0] fr);
    if (ex == '0) return '0;
    return {1'b0, 1'b1, fr, 1'b1};
  endfunction

  // Beyond M+2 positions every mantissa bit is shifted out, so larger distances saturate.
  function automatic logic [E:0] sat_shift(input logic signed [E:0] d);
    logic [E:0] mag;
    mag = d[E] ? $unsigned(-d) : $unsigned(d);
    return (mag > SHIFT_MAX) ? SHIFT_MAX : mag;
  endfunction

  logic                  sign_x_p0, sign_y_p0;
  logic [E-1:0]          exp_x_p0, exp_y_p0;
  logic [F-1:0]          frac_x_p0, frac_y_p0;
  logic signed [E:0]     diff_p0;

  logic                  vld_p1, sign_x_p1, sign_y_p1, ex_gt_p1, ex_eq_p1, frac_gt_p1;
  logic [E-1:0]          exp_x_p1, exp_y_p1;
  logic [F-1:0]          frac_x_p1, frac_y_p1;
  logic signed [E:0]     diff_p1;
  logic                  swap_p1;
  logic [M+1:0]          mant_x_p1, mant_y_p1;

  logic                  vld_p2, sign_large_p2, sign_small_p2, eff_sub_p2, swapped_p2;
  logic [M+1:0]          mant_large_p2, mant_small_p2;
  logic [E:0]            shift_p2;
  logic [E-1:0]          exp_large_p2;

  logic                  adv_p1, adv_p2, acc_p0;

  assign adv_p2   = !vld_p2 || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = adv_p1;
  assign acc_p0   = in_valid && adv_p1;

  // Stage 0: field extraction and the raw exponent difference
  assign sign_x_p0 = x_in[W-1];
  assign sign_y_p0 = y_in[W-1];
  assign exp_x_p0  = x_in[W-2:F];
  assign exp_y_p0  = y_in[W-2:F];
  assign frac_x_p0 = x_in[F-1:0];
  assign frac_y_p0 = y_in[F-1:0];
  assign diff_p0   = $signed({1'b0, exp_x_p0}) - $signed({1'b0, exp_y_p0});

  // Stage 1: registered fields and comparison flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      sign_x_p1  <= 1'b0;
      sign_y_p1  <= 1'b0;
      exp_x_p1   <= '0;
      exp_y_p1   <= '0;
      frac_x_p1  <= '0;
      frac_y_p1  <= '0;
      ex_gt_p1   <= 1'b0;
      ex_eq_p1   <= 1'b0;
      frac_gt_p1 <= 1'b0;
      diff_p1    <= '0;
    end else begin
      if (adv_p1) vld_p1 <= in_valid;
      if (acc_p0) begin
        sign_x_p1  <= sign_x_p0;
        sign_y_p1  <= sign_y_p0;
        exp_x_p1   <= exp_x_p0;
        exp_y_p1   <= exp_y_p0;
        frac_x_p1  <= frac_x_p0;
        frac_y_p1  <= frac_y_p0;
        ex_gt_p1   <= exp_x_p0 > exp_y_p0;
        ex_eq_p1   <= exp_x_p0 == exp_y_p0;
        frac_gt_p1 <= frac_x_p0 > frac_y_p0;
        diff_p1    <= diff_p0;
      end
    end
  end

  always_comb begin
    swap_p1   = (!ex_gt_p1 && !ex_eq_p1) ||
                (ex_eq_p1 && !frac_gt_p1 && (frac_x_p1 != frac_y_p1));
    mant_x_p1 = hub_mant(exp_x_p1, frac_x_p1);
    mant_y_p1 = hub_mant(exp_y_p1, frac_y_p1);
  end

  // Stage 2: ordered operands presented to the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2        <= 1'b0;
      mant_large_p2 <= '0;
      mant_small_p2 <= '0;
      shift_p2      <= '0;
      exp_large_p2  <= '0;
      sign_large_p2 <= 1'b0;
      sign_small_p2 <= 1'b0;
      eff_sub_p2    <= 1'b0;
      swapped_p2    <= 1'b0;
    end else begin
      if (adv_p2) vld_p2 <= vld_p1;
      if (adv_p2 && vld_p1) begin
        mant_large_p2 <= swap_p1 ? mant_y_p1 : mant_x_p1;
        mant_small_p2 <= swap_p1 ? mant_x_p1 : mant_y_p1;
        shift_p2      <= sat_shift(diff_p1);
        exp_large_p2  <= swap_p1 ? exp_y_p1 : exp_x_p1;
        sign_large_p2 <= swap_p1 ? sign_y_p1 : sign_x_p1;
        sign_small_p2 <= swap_p1 ? sign_x_p1 : sign_y_p1;
        eff_sub_p2    <= sign_x_p1 ^ sign_y_p1;
        swapped_p2    <= swap_p1;
      end
    end
  end

  assign out_valid    = vld_p2;
  assign mant_large   = mant_large_p2;
  assign mant_small   = mant_small_p2;
  assign shift_amount = shift_p2;
  assign exp_large    = exp_large_p2;
  assign sign_large   = sign_large_p2;
  assign sign_small   = sign_small_p2;
  assign eff_sub      = eff_sub_p2;
  assign swapped      = swapped_p2;

endmodule

// File: tb/tb_align_prep.sv
// Randomized scoreboard bench for align_prep (E=8, M=24) with directed corner cases,
// backpressure, and mid-flight reset.
module tb_align_prep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [25:0] mant_large, mant_small;
  logic [8:0]  shift_amount;
  logic [7:0]  exp_large;
  logic        sign_large, sign_small, eff_sub, swapped;

  align_prep #(.M(24), .E(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .mant_large(mant_large), .mant_small(mant_small), .shift_amount(shift_amount),
    .exp_large(exp_large), .sign_large(sign_large), .sign_small(sign_small),
    .eff_sub(eff_sub), .swapped(swapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] ml, ms;
    logic [8:0]  sh;
    logic [7:0]  el;
    logic        sl, ss, es, sw;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [25:0] mant_of(input logic [31:0] v);
    longint t;
    if (v[30:23] == 8'd0) return 26'd0;
    t = 64'd16777216 + (longint'(v[22:0]) * 2) + 1;
    return t[25:0];
  endfunction

  // Reference: magnitude ordering is just an integer compare of the low 31 bits.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    longint mx, my;
    int d;
    mx = longint'(x[30:0]);
    my = longint'(y[30:0]);
    r.sw = (my > mx);
    d = int'(x[30:23]) - int'(y[30:23]);
    if (d < 0) d = -d;
    if (d > 26) d = 26;
    r.sh = 9'(d);
    r.ml = r.sw ? mant_of(y) : mant_of(x);
    r.ms = r.sw ? mant_of(x) : mant_of(y);
    r.el = r.sw ? y[30:23] : x[30:23];
    r.sl = r.sw ? y[31] : x[31];
    r.ss = r.sw ? x[31] : y[31];
    r.es = x[31] ^ y[31];
    r.acc = 0;
    r.lat = 0;
    return r;
  endfunction

  task automatic send(input logic [31:0] x, input logic [31:0] y, input bit lat);
    exp_t e;
    int t;
    t = 0;
    in_valid = 1'b1;
    x_in = x;
    y_in = y;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk);
      #1;
      t++;
      if (t > 100) begin
        check("send_timeout", 32'(t), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    e = model(x, y);
    e.acc = cyc;
    e.lat = lat;
    q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    logic [7:0] ex;
    logic [22:0] fr;
    case ($urandom % 4)
      0: ex = 8'd0;
      1: begin
        case ($urandom % 4)
          0: ex = 8'd1;
          1: ex = 8'd127;
          2: ex = 8'd128;
          default: ex = 8'd254;
        endcase
      end
      default: ex = 8'($urandom);
    endcase
    fr = ($urandom % 3 == 0) ? 23'd0 : 23'($urandom);
    v = {1'($urandom), ex, fr};
    return v;
  endfunction

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compare at negedge, retire the entry at the consuming edge.
  initial begin
    bit consume, prev_stall;
    logic [25:0] s_ml, s_ms;
    logic [8:0]  s_sh;
    logic [7:0]  s_el;
    logic [3:0]  s_bits;
    exp_t e;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      consume = 0;
      if (rst_n) begin
        check("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
        if (prev_stall) begin
          check("stall_stable_ml", 32'(mant_large), 32'(s_ml));
          check("stall_stable_ms", 32'(mant_small), 32'(s_ms));
          check("stall_stable_sh", 32'(shift_amount), 32'(s_sh));
          check("stall_stable_el", 32'(exp_large), 32'(s_el));
          check("stall_stable_flags", 32'({sign_large, sign_small, eff_sub, swapped}), 32'(s_bits));
          check("stall_valid_held", 32'(out_valid), 32'd1);
        end
        if (out_valid && q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else if (out_valid && out_ready) begin
          e = q[0];
          consume = 1;
          check("mant_large", 32'(mant_large), 32'(e.ml));
          check("mant_small", 32'(mant_small), 32'(e.ms));
          check("shift_amount", 32'(shift_amount), 32'(e.sh));
          check("exp_large", 32'(exp_large), 32'(e.el));
          check("sign_large", 32'(sign_large), 32'(e.sl));
          check("sign_small", 32'(sign_small), 32'(e.ss));
          check("eff_sub", 32'(eff_sub), 32'(e.es));
          check("swapped", 32'(swapped), 32'(e.sw));
          if (e.lat) check("latency", 32'(cyc - e.acc), 32'd2);
        end
        prev_stall = out_valid && !out_ready;
        s_ml = mant_large;
        s_ms = mant_small;
        s_sh = shift_amount;
        s_el = exp_large;
        s_bits = {sign_large, sign_small, eff_sub, swapped};
      end else begin
        prev_stall = 0;
      end
      @(posedge clk);
      if (consume && q.size() > 0) void'(q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    #2;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_mant_large", 32'(mant_large), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases with out_ready held high
    send(32'h3F800000, 32'h40000000, 1);
    send(32'h40400000, 32'hC0000000, 1);
    send(32'h7F000000, 32'h00800000, 1);
    send(32'h3F800000, 32'h00000000, 1);
    send(32'h40490FDB, 32'h40490FDB, 1);
    send(32'hC0490FDB, 32'h40490FDC, 1);
    send(32'h00000000, 32'h7F7FFFFF, 1);
    drain();

    // Eight back-to-back pairs with a three-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op(), 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic and backpressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          x = rnd_op();
          case ($urandom % 4)
            0: y = {~x[31], x[30:0]};
            1: y = {1'($urandom), x[30:23], 23'($urandom)};
            default: y = rnd_op();
          endcase
          send(x, y, 0);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom % 3) != 0;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two pairs held in the pipeline
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 0);
    send(32'h41200000, 32'h3F000000, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mant_small", 32'(mant_small), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'h42C80000, 32'hC2C80001, 1);
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
